// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
// The state encoding always includes GAP so it is identical with or without LED_STRETCH_GAP_EN.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int LED_STRETCH_DEFAULT = 5_000_000;
    localparam int LED_GAP_DEFAULT     = 2_500_000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_stretch_one.sv
// Single-channel pulse stretcher: holds the output high for STRETCH_CYCLES after the last input high.
// With LED_STRETCH_GAP_EN defined, every blink is followed by a GAP_CYCLES forced-low gap.
module stretch_one
    import led_pkg::*;
#(
    parameter int STRETCH_CYCLES = LED_STRETCH_DEFAULT,
    parameter int GAP_CYCLES     = LED_GAP_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic led,
    output logic led_stretched
);

`ifdef LED_STRETCH_GAP_EN
    localparam int CW = max_int(cnt_width(STRETCH_CYCLES), cnt_width(GAP_CYCLES));
`else
    localparam int CW = cnt_width(STRETCH_CYCLES);
`endif

    localparam logic [CW-1:0] STRETCH_RELOAD = CW'(STRETCH_CYCLES - 1);

    // Standalone sanity checks so the channel cannot be built with a degenerate count.
    if (STRETCH_CYCLES < 2) begin : g_bad_stretch
        $error("stretch_one: STRETCH_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("stretch_one: GAP_CYCLES must be >= 1");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

`ifdef LED_STRETCH_GAP_EN
    localparam logic [CW-1:0] GAP_RELOAD = CW'(GAP_CYCLES - 1);

    logic pending;
    logic pending_nxt;

    // Reset wins over any led activity sampled on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
`endif

    // Counter only reloads or counts down to zero; a reload always beats the exit on cnt==0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef LED_STRETCH_GAP_EN
        pending_nxt = pending;
`endif
        case (state)
            IDLE: begin
                if (led) begin
                    state_nxt = ON;
                    cnt_nxt   = STRETCH_RELOAD;
                end
            end
            ON: begin
                if (led) begin
                    cnt_nxt = STRETCH_RELOAD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
`ifdef LED_STRETCH_GAP_EN
                    state_nxt = GAP;
                    cnt_nxt   = GAP_RELOAD;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef LED_STRETCH_GAP_EN
            // Events during the gap are remembered, not allowed to shorten or extend it.
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                    if (led) begin
                        pending_nxt = 1'b1;
                    end
                end else if (pending || led) begin
                    state_nxt   = ON;
                    cnt_nxt     = STRETCH_RELOAD;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign led_stretched = (state == ON);

endmodule

// File: rtl/led_stretch.sv
// Multi-channel LED pulse stretcher: one independent stretch_one per output bit.
// Optional forced gap between blinks is enabled by defining LED_STRETCH_GAP_EN.
module led_stretch
    import led_pkg::*;
#(
    parameter int OUTPUTS        = 16,
    parameter int STRETCH_CYCLES = LED_STRETCH_DEFAULT,
    parameter int GAP_CYCLES     = LED_GAP_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [OUTPUTS-1:0] led,
    output logic [OUTPUTS-1:0] led_stretched
);

    if (STRETCH_CYCLES < 2) begin : g_bad_stretch
        $error("led_stretch: STRETCH_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("led_stretch: GAP_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_chan
        stretch_one #(
            .STRETCH_CYCLES(STRETCH_CYCLES),
            .GAP_CYCLES    (GAP_CYCLES)
        ) u_stretch (
            .clock        (clock),
            .reset        (reset),
            .led          (led[i]),
            .led_stretched(led_stretched[i])
        );
    end

endmodule

// File: tb/tb_led_stretch.sv
// Scoreboard bench for led_stretch: an interval-based reference model predicts each cycle's output.
module tb_led_stretch;

    localparam int OUTPUTS = 16;
    localparam int STRETCH = 4;
    localparam int GAP     = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [OUTPUTS-1:0] led   = '0;
    logic [OUTPUTS-1:0] led_stretched;

    always #5 clock = ~clock;

    led_stretch #(
        .OUTPUTS       (OUTPUTS),
        .STRETCH_CYCLES(STRETCH),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .led          (led),
        .led_stretched(led_stretched)
    );

    logic [OUTPUTS-1:0] expQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;
    bit    started     = 1'b0;
    longint edgeNum    = 0;

    // Model state: last edge index at which each channel is still lit, end of its gap, pending event.
    longint blinkEnd[OUTPUTS];
    longint gapEnd[OUTPUTS];
    bit     pend[OUTPUTS];

    initial begin
        for (int i = 0; i < OUTPUTS; i++) begin
            blinkEnd[i] = -1000;
            gapEnd[i]   = -1000;
            pend[i]     = 1'b0;
        end
    end

    // Output after edge e is high iff e <= blinkEnd; each accepted event lights edges e..e+STRETCH-1.
    function automatic logic [OUTPUTS-1:0] modelStep(input logic rst, input logic [OUTPUTS-1:0] l,
                                                     input longint e);
        logic [OUTPUTS-1:0] res;
        res = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (!rst) begin
                blinkEnd[i] = -1000;
                gapEnd[i]   = -1000;
                pend[i]     = 1'b0;
            end else if (e - 1 <= blinkEnd[i]) begin
                if (l[i]) begin
                    blinkEnd[i] = e + STRETCH - 1;
                end
`ifdef LED_STRETCH_GAP_EN
                else if (e - 1 == blinkEnd[i]) begin
                    gapEnd[i] = blinkEnd[i] + GAP;
                end
`endif
            end
`ifdef LED_STRETCH_GAP_EN
            else if (e - 1 <= gapEnd[i]) begin
                if (e - 1 < gapEnd[i]) begin
                    pend[i] = pend[i] | l[i];
                end else if (pend[i] || l[i]) begin
                    blinkEnd[i] = e + STRETCH - 1;
                    pend[i]     = 1'b0;
                end
            end
`endif
            else if (l[i]) begin
                blinkEnd[i] = e + STRETCH - 1;
            end
            res[i] = (e <= blinkEnd[i]);
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [OUTPUTS-1:0] l);
        @(negedge clock);
        reset = rst;
        led   = l;
        expQ.push_back(modelStep(rst, l, edgeNum));
        edgeNum++;
        started = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, '0);
    endtask

    task automatic checkOutput();
        logic [OUTPUTS-1:0] exp;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_underflow: got=%h, no expected value queued", led_stretched);
        end else begin
            exp = expQ.pop_front();
            if (led_stretched !== exp) begin
                testsFailed++;
                $display("[TB] FAIL led_stretched cycle %0d: got=%h expected=%h",
                         testsRun, led_stretched, exp);
            end
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (started) checkOutput();
    end

    initial begin
        logic [OUTPUTS-1:0] rl;
        logic               rr;

        // Reset held with all inputs high, then released idle.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'hFFFF);
        idleCycles(4);

        // Single pulse on bit 0.
        applyStimulus(1'b1, 16'h0001);
        idleCycles(6);

        // Level held 10 cycles on bit 3.
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 16'h0008);
        idleCycles(16);

        // Retrigger exactly when the counter reaches zero.
        applyStimulus(1'b1, 16'h0004);
        idleCycles(3);
        applyStimulus(1'b1, 16'h0004);
        idleCycles(12);

        // Reset two cycles into a stretch on bit 7.
        applyStimulus(1'b1, 16'h0080);
        idleCycles(1);
        applyStimulus(1'b0, 16'h0000);
        idleCycles(6);

        // Staggered pulses on bits 0, 5 and 15.
        applyStimulus(1'b1, 16'h0001);
        idleCycles(1);
        applyStimulus(1'b1, 16'h0020);
        applyStimulus(1'b1, 16'h8000);
        idleCycles(12);

        // Two pulses five cycles apart on bit 1.
        applyStimulus(1'b1, 16'h0002);
        idleCycles(4);
        applyStimulus(1'b1, 16'h0002);
        idleCycles(14);

        // Randomised traffic with sparse events and occasional resets.
        for (int k = 0; k < 400; k++) begin
            rr = ($urandom_range(0, 49) != 0);
            for (int b = 0; b < OUTPUTS; b++) rl[b] = ($urandom_range(0, 7) == 0);
            applyStimulus(rr, rl);
        end
        idleCycles(20);

        @(posedge clock);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got=%0d leftover entries expected=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
